fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer for the MCU, sitting directly upstream of the program ROM and downstream-adjacent to decode. It owns the program counter and drives the ROM's address/read-enable pair (MAR, LDMAR). It samples the returned word (MDR) after a fixed read latency and buffers fetched instructions with their PCs in a small queue. Decode drains the queue through a valid/ready handshake; branch redirects flush the queue and squash any in-flight read.

## Interface
- ADDR_W, 16, address width (word-addressed)
- DATA_W, 16, instruction width
- RESET_PC, 16'h0000, PC after reset
- READ_LAT, 1, cycles per ROM access (legal 1..4)
- QDEPTH, 2, instruction queue entries (legal 2..4)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- MAR  out  ADDR_W  ROM address; registered
- LDMAR  out  1  ROM read enable, level; registered
- MDR  in  DATA_W  ROM read data
- instr  out  DATA_W  queue head instruction
- instr_pc  out  ADDR_W  PC of queue head
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decode accepts head; pop = instr_valid & instr_ready
- redirect  in  1  one-cycle branch/jump request
- redirect_pc  in  ADDR_W  new PC
- halt  in  1  inhibit starting new accesses

## Operation
- FSM states:
  - IDLE: LDMAR=0.
  - ACCESS: LDMAR=1, MAR=PC held stable, internal cycle counter runs 0..READ_LAT-1.
- At most one access is outstanding. Accesses are not pipelined.
- Capture: in the last ACCESS cycle (counter==READ_LAT-1), {MDR, MAR} is pushed into the queue at the closing edge, PC<=PC+1 (mod 2^ADDR_W, FFFF->0000), and the counter is cleared.
- Start/continue condition, evaluated with no redirect and halt=0:
  - From IDLE: count−pop < QDEPTH.
  - From a capture cycle: count+1−pop < QDEPTH.
  - True: the FSM enters or stays in ACCESS with the new PC. False: IDLE.
- halt=1: no new access starts. An in-flight access completes and captures, then the FSM goes to IDLE. The queue continues to drain.
- redirect=1 has priority over capture, pop and start:
  - At the edge: queue flushed (count=0), in-flight access discarded with no push, PC<=redirect_pc, FSM<=IDLE.
  - A pop in the same cycle has no additional effect.
  - The next access starts the following cycle.
- Queue is FIFO. Push and pop are allowed in the same cycle. Push into a full queue cannot occur by construction; flag it with an assertion.

## Timing
- Reset values: MAR=RESET_PC, LDMAR=0, instr=0, instr_pc=0, instr_valid=0, PC=RESET_PC, FSM=IDLE, queue empty.
- Async reset mid-access forces reset values immediately, with no clock required. The in-flight access is lost.
- Cycle 0 is the first cycle after rst_n deasserts: FSM is in IDLE and starts.
- Cycle 1: LDMAR=1, MAR=RESET_PC.
- READ_LAT=1: capture at end of cycle 1, instr_valid=1 in cycle 2. LDMAR stays high continuously and MAR advances one per cycle. Throughput is 1 instruction/cycle while decode accepts.
- READ_LAT=N: LDMAR high for N cycles per address, back to back. Throughput is 1 per N cycles.
- Redirect in cycle t: LDMAR=0 in t+1, LDMAR=1 with MAR=redirect_pc in t+2, first redirected instr_valid at t+2+READ_LAT.
- instr and instr_pc are stable while instr_valid=1 and instr_ready=0.

## Structure
- Shared package mcu_pkg: ADDR_W, DATA_W, fetch FSM state enum {IDLE, ACCESS}, queue entry struct {pc, instr}.
- Sub-module fetch_queue: synchronous FIFO with QDEPTH entries, push, pop and flush (flush dominant), outputs count and head.
- fetch_unit holds the PC, the FSM, the latency counter and the start logic.

## Test plan
- Reset release, READ_LAT=1, instr_ready=1, ROM word[a]=a^16'hA5A5 -> LDMAR high from cycle 1; MAR 0000,0001,…; instr A5A5/pc 0000 in cycle 2, then one per cycle with no gaps.
- QDEPTH=2, instr_ready=0 -> two captures (pc 0000, 0001), then LDMAR=0 with MAR held at 0002. Raising instr_ready resumes at pc 0002 with no loss or duplicate.
- READ_LAT=3 -> each MAR value is held exactly 3 cycles with LDMAR=1; instructions delivered every 3 cycles.
- redirect with redirect_pc=0100 during the second cycle of a READ_LAT=3 access -> no push of the squashed word; instr_valid=0 next cycle; next delivered instr_pc=0100.
- redirect_pc=FFFF -> delivered PCs FFFF then 0000 (wrap).
- rst_n pulsed low mid-access, asynchronous to clk -> LDMAR and instr_valid drop without a clock edge; refetch restarts at RESET_PC.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared MCU definitions: bus widths, fetch FSM states and the queue entry layout.
package mcu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: ROM address/read-enable/data plus the decode-side
// instruction handshake and the control inputs from the core.
//
// Handshake: instr_valid/instr_ready is strict valid/ready. The fetch unit
// raises instr_valid whenever its queue holds an entry and keeps instr and
// instr_pc unchanged until the entry is taken. A transfer (pop) happens on
// every rising edge where instr_valid & instr_ready are both high. instr_ready
// may be driven freely and never depends on instr_valid being low.
interface fetch_unit_if;
  import mcu_pkg::*;

  logic [ADDR_W-1:0] MAR;
  logic              LDMAR;
  logic [DATA_W-1:0] MDR;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;

  // Fetch unit side.
  modport master (
    output MAR, LDMAR, instr, instr_pc, instr_valid,
    input  MDR, instr_ready, redirect, redirect_pc, halt
  );

  // ROM / decode / core side.
  modport slave (
    input  MAR, LDMAR, instr, instr_pc, instr_valid,
    output MDR, instr_ready, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries. Flush dominates push
// and pop; head reads as zero while the queue is empty.
module fetch_queue
  import mcu_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(QDEPTH+1)-1:0]  count,
  output fetch_entry_t                 head
);

  localparam int PTR_W = $clog2(QDEPTH);

  fetch_entry_t     mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointer advance with wrap at the (possibly non power-of-two) depth.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observable through head when count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  // The start logic only launches an access when a slot will be free at capture.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> (int'(count) < QDEPTH)
  );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, runs one non-pipelined ROM access
// at a time (MAR/LDMAR), captures MDR after READ_LAT cycles into a small queue
// and hands instructions to decode. Redirect flushes everything and restarts.
module fetch_unit
  import mcu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                READ_LAT = 1,
  parameter int                QDEPTH   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
  output fetch_state_t dbg_state
);

  fetch_state_t                state;
  fetch_state_t                state_d;
  logic [ADDR_W-1:0]           pc;
  logic [ADDR_W-1:0]           pc_d;
  logic [1:0]                  cnt;
  logic [1:0]                  cnt_d;
  logic                        push;
  logic                        pop;
  logic                        last;
  logic                        room_idle;
  logic                        room_cont;
  logic [$clog2(QDEPTH+1)-1:0] count;
  fetch_entry_t                head;
  fetch_entry_t                push_data;

  assign pop  = bus.instr_valid & bus.instr_ready;
  assign last = (cnt == 2'(READ_LAT - 1));

  // Room checks: an access may begin only if its word will fit at capture time.
  assign room_idle = (int'(count) - int'(pop)) < QDEPTH;
  assign room_cont = (int'(count) + 1 - int'(pop)) < QDEPTH;

  // MAR always shows the PC of the current or next access.
  assign push_data = '{pc: pc, instr: bus.MDR};

  // State, PC and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic: redirect beats capture, pop and start.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    cnt_d   = cnt;
    push    = 1'b0;
    if (bus.redirect) begin
      state_d = IDLE;
      pc_d    = bus.redirect_pc;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.halt && room_idle) state_d = ACCESS;
        end
        ACCESS: begin
          if (last) begin
            push    = 1'b1;
            pc_d    = pc + 1'b1;
            cnt_d   = '0;
            state_d = (!bus.halt && room_cont) ? ACCESS : IDLE;
          end else begin
            cnt_d = cnt + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect),
    .count     (count),
    .head      (head)
  );

  assign bus.MAR         = pc;
  assign bus.LDMAR       = (state == ACCESS);
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.instr_valid = (count != '0);
  assign dbg_state       = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (READ_LAT=1 and READ_LAT=3, QDEPTH=2)
// against a ROM whose word[a] = a ^ 16'hA5A5. A stream-level model predicts
// queue contents, the address being fetched and whether a read is in progress;
// directed phases add hand-computed literal checks.
module tb_fetch_unit;
  import mcu_pkg::*;

  localparam int QD = 2;

  logic clk;
  logic rst_n;
  fetch_state_t st1;
  fetch_state_t st3;

  fetch_unit_if bus1 ();
  fetch_unit_if bus3 ();

  assign bus1.MDR = bus1.MAR ^ 16'hA5A5;
  assign bus3.MDR = bus3.MAR ^ 16'hA5A5;

  fetch_unit #(.RESET_PC(16'h0000), .READ_LAT(1), .QDEPTH(QD)) u_fu1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(st1)
  );
  fetch_unit #(.RESET_PC(16'h0000), .READ_LAT(3), .QDEPTH(QD)) u_fu3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .dbg_state(st3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // exp_q[id] holds {pc, instr} words fetched but not yet taken by decode.
  logic [31:0] exp_q [2][$];
  logic        exp_ldmar [2];
  logic [15:0] exp_mar [2];
  int          run [2];

  task automatic model_reset(input int id);
    exp_q[id].delete();
    exp_ldmar[id] = 1'b0;
    exp_mar[id]   = 16'h0000;
    run[id]       = 0;
  endtask

  // One cycle of the model: compare this cycle's outputs, then advance to the
  // state after the coming edge. A read completes once the address has been
  // presented for lat cycles; a new read is under way after the edge if the
  // current one is unfinished, or if the queue then has room for one more word.
  task automatic model_cycle(input int id, input int lat,
                             input logic ldmar, input logic [15:0] mar,
                             input logic valid, input logic [15:0] ins,
                             input logic [15:0] ipc, input logic ready,
                             input logic redir, input logic [15:0] rpc,
                             input logic hlt);
    logic cap;
    string p;
    p = $sformatf("u%0d", lat);
    chk({p, "_ldmar"}, 32'(ldmar), 32'(exp_ldmar[id]));
    chk({p, "_mar"}, 32'(mar), 32'(exp_mar[id]));
    chk({p, "_valid"}, 32'(valid), 32'(exp_q[id].size() > 0));
    if (exp_q[id].size() > 0) chk({p, "_head"}, {ipc, ins}, exp_q[id][0]);

    cap = 1'b0;
    if (ldmar) begin
      run[id]++;
      if (run[id] == lat) cap = 1'b1;
    end
    if (redir) begin
      exp_q[id].delete();
      run[id]       = 0;
      exp_mar[id]   = rpc;
      exp_ldmar[id] = 1'b0;
    end else begin
      if (valid && ready && exp_q[id].size() > 0) void'(exp_q[id].pop_front());
      if (cap) begin
        exp_q[id].push_back({mar, mar ^ 16'hA5A5});
        run[id]     = 0;
        exp_mar[id] = mar + 16'h0001;
      end
      exp_ldmar[id] = (ldmar && !cap) ? 1'b1 : (!hlt && exp_q[id].size() < QD);
    end
  endtask

  // Compare process: every cycle out of reset, at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_cycle(0, 1, bus1.LDMAR, bus1.MAR, bus1.instr_valid, bus1.instr, bus1.instr_pc,
                  bus1.instr_ready, bus1.redirect, bus1.redirect_pc, bus1.halt);
      model_cycle(1, 3, bus3.LDMAR, bus3.MAR, bus3.instr_valid, bus3.instr, bus3.instr_pc,
                  bus3.instr_ready, bus3.redirect, bus3.redirect_pc, bus3.halt);
    end
  end

  // ---------------- driver tasks ----------------
  // Advance to the falling edge of cycle n (cycle 0 = first cycle after release).
  task automatic goto_neg(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Position just after the rising edge that begins cycle n.
  task automatic start_of(input int n);
    goto_neg(n - 1);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = -1;
  endtask

  task automatic do_reset(input logic rdy1, input logic rdy3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus1.instr_ready = rdy1;
    bus3.instr_ready = rdy3;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic set_ctl(input logic rdy1, input logic rdy3, input logic hlt);
    bus1.instr_ready = rdy1;
    bus3.instr_ready = rdy3;
    bus1.halt        = hlt;
    bus3.halt        = hlt;
    bus1.redirect    = 1'b0;
    bus3.redirect    = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    bus1.redirect_pc = 16'h0000;
    bus3.redirect_pc = 16'h0000;
    set_ctl(1'b1, 1'b1, 1'b0);

    // Reset values.
    repeat (2) @(posedge clk);
    #3;
    chk("rst_mar", 32'(bus1.MAR), 32'h0000);
    chk("rst_ldmar", 32'(bus1.LDMAR), 32'h0);
    chk("rst_instr", 32'(bus1.instr), 32'h0000);
    chk("rst_instr_pc", 32'(bus1.instr_pc), 32'h0000);
    chk("rst_valid", 32'(bus1.instr_valid), 32'h0);
    chk("rst_state", 32'(st1), 32'(IDLE));
    chk("rst_ldmar3", 32'(bus3.LDMAR), 32'h0);

    // Phase 1: free-running fetch, decode always ready.
    release_reset();
    goto_neg(0);
    chk("p1_c0_ldmar", 32'(bus1.LDMAR), 32'h0);
    goto_neg(1);
    chk("p1_c1_ldmar", 32'(bus1.LDMAR), 32'h1);
    chk("p1_c1_mar", 32'(bus1.MAR), 32'h0000);
    chk("p1_c1_ldmar3", 32'(bus3.LDMAR), 32'h1);
    goto_neg(2);
    chk("p1_c2_valid", 32'(bus1.instr_valid), 32'h1);
    chk("p1_c2_instr", 32'(bus1.instr), 32'hA5A5);
    chk("p1_c2_pc", 32'(bus1.instr_pc), 32'h0000);
    chk("p1_c2_mar", 32'(bus1.MAR), 32'h0001);
    goto_neg(3);
    chk("p1_c3_instr", 32'(bus1.instr), 32'hA5A4);
    chk("p1_c3_pc", 32'(bus1.instr_pc), 32'h0001);
    chk("p1_c3_mar3", 32'(bus3.MAR), 32'h0000);
    chk("p1_c3_ldmar3", 32'(bus3.LDMAR), 32'h1);
    goto_neg(4);
    chk("p1_c4_valid3", 32'(bus3.instr_valid), 32'h1);
    chk("p1_c4_pc3", 32'(bus3.instr_pc), 32'h0000);
    chk("p1_c4_mar3", 32'(bus3.MAR), 32'h0001);
    goto_neg(12);

    // Phase 2: decode stalled on the READ_LAT=1 unit, then resumes.
    do_reset(1'b0, 1'b1);
    goto_neg(2);
    chk("p2_c2_pc", 32'(bus1.instr_pc), 32'h0000);
    chk("p2_c2_mar", 32'(bus1.MAR), 32'h0001);
    goto_neg(3);
    chk("p2_c3_ldmar", 32'(bus1.LDMAR), 32'h0);
    chk("p2_c3_mar", 32'(bus1.MAR), 32'h0002);
    goto_neg(6);
    chk("p2_c6_ldmar", 32'(bus1.LDMAR), 32'h0);
    chk("p2_c6_pc", 32'(bus1.instr_pc), 32'h0000);
    start_of(7);
    bus1.instr_ready = 1'b1;
    goto_neg(8);
    chk("p2_c8_ldmar", 32'(bus1.LDMAR), 32'h1);
    chk("p2_c8_mar", 32'(bus1.MAR), 32'h0002);
    chk("p2_c8_pc", 32'(bus1.instr_pc), 32'h0001);
    goto_neg(9);
    chk("p2_c9_pc", 32'(bus1.instr_pc), 32'h0002);
    chk("p2_c9_instr", 32'(bus1.instr), 32'hA5A7);
    goto_neg(14);

    // Phase 3: redirect in the second cycle of a READ_LAT=3 access.
    do_reset(1'b1, 1'b0);
    goto_neg(4);
    chk("p3_c4_pc3", 32'(bus3.instr_pc), 32'h0000);
    start_of(5);
    bus3.redirect_pc = 16'h0100;
    bus3.redirect    = 1'b1;
    start_of(6);
    bus3.redirect    = 1'b0;
    goto_neg(6);
    chk("p3_c6_valid3", 32'(bus3.instr_valid), 32'h0);
    chk("p3_c6_ldmar3", 32'(bus3.LDMAR), 32'h0);
    goto_neg(7);
    chk("p3_c7_ldmar3", 32'(bus3.LDMAR), 32'h1);
    chk("p3_c7_mar3", 32'(bus3.MAR), 32'h0100);
    goto_neg(9);
    chk("p3_c9_valid3", 32'(bus3.instr_valid), 32'h0);
    goto_neg(10);
    chk("p3_c10_valid3", 32'(bus3.instr_valid), 32'h1);
    chk("p3_c10_pc3", 32'(bus3.instr_pc), 32'h0100);
    chk("p3_c10_instr3", 32'(bus3.instr), 32'hA4A5);
    bus3.instr_ready = 1'b1;
    goto_neg(16);

    // Phase 4: redirect to the top of the address space, PC wraps.
    n = cyc + 1;
    start_of(n);
    bus1.redirect_pc = 16'hFFFF;
    bus1.redirect    = 1'b1;
    start_of(n + 1);
    bus1.redirect    = 1'b0;
    goto_neg(n + 1);
    chk("p4_t1_ldmar", 32'(bus1.LDMAR), 32'h0);
    goto_neg(n + 2);
    chk("p4_t2_mar", 32'(bus1.MAR), 32'hFFFF);
    goto_neg(n + 3);
    chk("p4_t3_pc", 32'(bus1.instr_pc), 32'hFFFF);
    chk("p4_t3_instr", 32'(bus1.instr), 32'h5A5A);
    chk("p4_t3_mar", 32'(bus1.MAR), 32'h0000);
    goto_neg(n + 4);
    chk("p4_t4_pc", 32'(bus1.instr_pc), 32'h0000);
    chk("p4_t4_instr", 32'(bus1.instr), 32'hA5A5);
    goto_neg(n + 6);

    // Phase 5: halt lets the in-flight read finish, then stops issuing.
    n = cyc + 1;
    start_of(n);
    set_ctl(1'b1, 1'b1, 1'b1);
    goto_neg(n + 1);
    chk("p5_ldmar", 32'(bus1.LDMAR), 32'h0);
    goto_neg(n + 2);
    chk("p5_drained", 32'(bus1.instr_valid), 32'h0);
    goto_neg(n + 6);
    chk("p5_ldmar3", 32'(bus3.LDMAR), 32'h0);
    start_of(n + 7);
    set_ctl(1'b1, 1'b1, 1'b0);

    // Phase 6: mixed ready/halt/redirect traffic checked by the model.
    for (int i = 0; i < 80; i++) begin
      start_of(cyc + 1);
      set_ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) begin
        bus1.redirect_pc = 16'($urandom_range(0, 65535));
        bus1.redirect    = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        bus3.redirect_pc = 16'($urandom_range(0, 65535));
        bus3.redirect    = 1'b1;
      end
    end
    start_of(cyc + 1);
    set_ctl(1'b1, 1'b1, 1'b0);
    goto_neg(cyc + 7);

    // Phase 7: asynchronous reset between clock edges during an access.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("p7_ldmar", 32'(bus1.LDMAR), 32'h0);
    chk("p7_valid", 32'(bus1.instr_valid), 32'h0);
    chk("p7_ldmar3", 32'(bus3.LDMAR), 32'h0);
    chk("p7_valid3", 32'(bus3.instr_valid), 32'h0);
    chk("p7_mar", 32'(bus1.MAR), 32'h0000);
    repeat (2) @(posedge clk);
    release_reset();
    goto_neg(1);
    chk("p7_c1_ldmar", 32'(bus1.LDMAR), 32'h1);
    chk("p7_c1_mar", 32'(bus1.MAR), 32'h0000);
    goto_neg(2);
    chk("p7_c2_pc", 32'(bus1.instr_pc), 32'h0000);
    chk("p7_c2_instr", 32'(bus1.instr), 32'hA5A5);
    goto_neg(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
